vector_element_sequencer: RTL

//  Consumes one decoded vector instruction per handshake from the vector control unit and expands it into

---
 rtl/vector_seq_pkg.sv | 38 +++
 rtl/vseq_reg_map.sv | 27 ++
 rtl/vector_element_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vector_seq_pkg.sv
// Shared types and helpers for the vector element sequencer.
// fu_t mirrors the functional-unit encoding used by the vector decode stage.
package vector_seq_pkg;

    typedef enum logic [0:0] {
        IDLE,
        ISSUE
    } seq_state_t;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2
    } sew_t;

    typedef logic [2:0] eew_t;

    localparam eew_t EEW8  = 3'd0;
    localparam eew_t EEW16 = 3'd1;
    localparam eew_t EEW32 = 3'd2;
    localparam eew_t EEW64 = 3'd3;

    typedef enum logic [2:0] {
        FU_VALU  = 3'd0,
        FU_VMUL  = 3'd1,
        FU_VDIV  = 3'd2,
        FU_VLSU  = 3'd3,
        FU_VPERM = 3'd4
    } fu_t;

    // log2 of elements per register for a given eew; saturates at one element
    function automatic int epr_shift(input eew_t eew, input int vlen);
        int s;
        s = $clog2(vlen / 8) - int'(eew);
        return (s < 0) ? 0 : s;
    endfunction

endpackage

// File: rtl/vseq_reg_map.sv
// Maps an element index to the register holding it and its offset within
// that register, for one operand of a given effective element width.
module vseq_reg_map
    import vector_seq_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int VL_W  = 8,
    parameter int OFF_W = 4
) (
    input  logic [4:0]       base,
    input  logic [VL_W-1:0]  elem,
    input  eew_t             eew,
    output logic [4:0]       reg_num,
    output logic [OFF_W-1:0] off
);

    int              shift;
    logic [VL_W-1:0] mask;

    always_comb begin
        shift   = epr_shift(eew, VLEN);
        mask    = VL_W'((1 << shift) - 1);
        reg_num = base + 5'(elem >> shift);
        off     = OFF_W'(elem & mask);
    end

endmodule

// File: rtl/vector_element_sequencer.sv
// Expands one decoded vector instruction into LANES-wide element beats.
// Optional VSEQ_PERF_CNT_EN adds accepted-beat and stall-cycle counters.
module vector_element_sequencer
    import vector_seq_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int LANES = 2,
    parameter int VL_W  = 8,
    parameter int OFF_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VL_W-1:0]  vl,
    input  logic [VL_W-1:0]  vstart,
    input  logic [1:0]       sew,
    input  logic             vd_widen,
    input  logic             vs2_widen,
    input  logic             vd_narrow,
    input  logic [4:0]       vs1,
    input  logic [4:0]       vs2,
    input  logic [4:0]       vd,
    input  logic             vm,
    input  logic             imm_op,
    input  fu_t              fu_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_vs1,
    output logic [4:0]       out_vs2,
    output logic [4:0]       out_vd,
    output logic [OFF_W-1:0] out_vs1_off,
    output logic [OFF_W-1:0] out_vs2_off,
    output logic [OFF_W-1:0] out_vd_off,
    output logic [LANES-1:0] out_lane_active,
    output logic [VL_W-1:0]  out_elem_idx,
    output logic             out_first,
    output logic             out_last,
    output logic             out_vm,
    output logic             out_imm_op,
    output fu_t              out_fu_type,
    output logic             done,
    output logic             busy
`ifdef VSEQ_PERF_CNT_EN
    ,
    output logic [31:0]      perf_beats,
    output logic [31:0]      perf_stall
`endif
);

    seq_state_t      state_q, state_d;
    logic [VL_W-1:0] vl_q, vstart_q, elem_q, elem_d;
    logic            first_q, first_d, done_d;
    logic [4:0]      vs1_q, vs2_q, vd_q;
    eew_t            eew_vs1_q, eew_vs2_q, eew_vd_q;
    logic            vm_q, imm_q;
    fu_t             fu_q;
    logic            beat_fire, accept;
    logic [VL_W:0]   last_sum, lane_pos;

    assign out_valid    = (state_q == ISSUE);
    assign busy         = (state_q == ISSUE);
    assign beat_fire    = out_valid & out_ready;
    assign last_sum     = {1'b0, elem_q} + (VL_W+1)'(LANES);
    assign out_last     = out_valid & (last_sum >= {1'b0, vl_q});
    assign out_first    = out_valid & first_q;
    assign in_ready     = ~rst & ~flush & ((state_q == IDLE) | (beat_fire & out_last));
    assign accept       = in_valid & in_ready;
    assign out_elem_idx = elem_q;
    assign out_vm       = vm_q;
    assign out_imm_op   = imm_q;
    assign out_fu_type  = fu_q;

    always_comb begin
        lane_pos        = '0;
        out_lane_active = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_pos = {1'b0, elem_q} + (VL_W+1)'(k);
            out_lane_active[k] = out_valid && (lane_pos >= {1'b0, vstart_q})
                                           && (lane_pos < {1'b0, vl_q});
        end
    end

    // A new instruction accepted alongside the last beat overrides the return to IDLE
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        first_d = first_q;
        done_d  = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            if (beat_fire) begin
                elem_d  = elem_q + VL_W'(LANES);
                first_d = 1'b0;
                if (out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            if (accept) begin
                if (vstart >= vl) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ISSUE;
                    elem_d  = vstart & ~VL_W'(LANES - 1);
                    first_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            elem_q    <= '0;
            first_q   <= 1'b0;
            done      <= 1'b0;
            vl_q      <= '0;
            vstart_q  <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            eew_vs1_q <= EEW8;
            eew_vs2_q <= EEW8;
            eew_vd_q  <= EEW8;
            vm_q      <= 1'b0;
            imm_q     <= 1'b0;
            fu_q      <= FU_VALU;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            first_q <= first_d;
            done    <= done_d;
            if (accept) begin
                vl_q      <= vl;
                vstart_q  <= vstart;
                vs1_q     <= vs1;
                vs2_q     <= vs2;
                vd_q      <= vd;
                eew_vs1_q <= {1'b0, sew};
                eew_vs2_q <= {1'b0, sew} + {2'b0, vs2_widen | vd_narrow};
                eew_vd_q  <= {1'b0, sew} + {2'b0, vd_widen};
                vm_q      <= vm;
                imm_q     <= imm_op;
                fu_q      <= fu_type;
            end
        end
    end

    vseq_reg_map #(.VLEN(VLEN), .VL_W(VL_W), .OFF_W(OFF_W)) u_map_vs1 (
        .base(vs1_q), .elem(elem_q), .eew(eew_vs1_q), .reg_num(out_vs1), .off(out_vs1_off)
    );

    vseq_reg_map #(.VLEN(VLEN), .VL_W(VL_W), .OFF_W(OFF_W)) u_map_vs2 (
        .base(vs2_q), .elem(elem_q), .eew(eew_vs2_q), .reg_num(out_vs2), .off(out_vs2_off)
    );

    vseq_reg_map #(.VLEN(VLEN), .VL_W(VL_W), .OFF_W(OFF_W)) u_map_vd (
        .base(vd_q), .elem(elem_q), .eew(eew_vd_q), .reg_num(out_vd), .off(out_vd_off)
    );

`ifdef VSEQ_PERF_CNT_EN
    // Counters ignore flush so stall accounting survives squashed instructions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_beats <= '0;
            perf_stall <= '0;
        end else begin
            if (beat_fire) begin
                perf_beats <= perf_beats + 32'd1;
            end
            if (out_valid & ~out_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
